bus_requester: RTL and testbench

- Master-side counterpart to the team's idle/busy/wait/free bus grant FSM.
- Accepts a transfer command, raises req, waits for gnt, then streams cmd_len+1 data beats from a local source onto the bus.
- Signals done on the final beat and optionally holds the bus afterwards with dly for a fixed number of cycles.
- Sits between a local data producer and the shared-bus arbiter.

---
 rtl/bus_requester_if.sv | 35 +++
 rtl/bus_requester.sv | 145 ++++++++++++++
 tb/tb_bus_requester.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/bus_requester_if.sv
// Bundles the command, source, arbiter and bus-side signals of bus_requester.
// master = the requester itself, slave = its environment (producer/arbiter).
interface bus_requester_if #(
    parameter int DATA_W = 8,
    parameter int LEN_W  = 4
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [LEN_W-1:0]  cmd_len;
    logic              cmd_hold;
    logic              src_valid;
    logic              src_ready;
    logic [DATA_W-1:0] src_data;
    logic              req;
    logic              gnt;
    logic              done;
    logic              dly;
    logic              bus_valid;
    logic [DATA_W-1:0] bus_data;
    logic              busy;
    logic              err;
    logic              timeout;

    modport master (
        input  cmd_valid, cmd_len, cmd_hold, src_valid, src_data, gnt,
        output cmd_ready, src_ready, req, done, dly, bus_valid, bus_data,
        output busy, err, timeout
    );

    modport slave (
        output cmd_valid, cmd_len, cmd_hold, src_valid, src_data, gnt,
        input  cmd_ready, src_ready, req, done, dly, bus_valid, bus_data,
        input  busy, err, timeout
    );
endinterface

// File: rtl/bus_requester.sv
// Bus master: takes a command, requests the bus, streams cmd_len+1 beats, optional dly hold.
// Optional grant-wait timeout enabled by defining BUS_REQ_TIMEOUT_EN.
module bus_requester #(
    parameter int DATA_W   = 8,
    parameter int LEN_W    = 4,
    parameter int HOLD_CYC = 2,
    parameter int TIMEOUT  = 16
) (
    input  logic clk,
    input  logic rst_n,
    bus_requester_if.master bif
);
    localparam int HC_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

    if (HOLD_CYC < 1) begin : g_hold_chk
        $error("HOLD_CYC must be >= 1");
    end
    if (TIMEOUT < 1) begin : g_tmo_chk
        $error("TIMEOUT must be >= 1");
    end

    typedef enum logic [1:0] {IDLE, REQ, XFER, HOLD} state_t;

    state_t            state, state_nx;
    logic [LEN_W-1:0]  beat_cnt, beat_cnt_nx;
    logic [HC_W-1:0]   hold_cnt, hold_cnt_nx;
    logic              hold_f, hold_f_nx;
    logic              err_q, err_nx;

`ifdef BUS_REQ_TIMEOUT_EN
    localparam int WC_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [WC_W-1:0]   wait_cnt, wait_cnt_nx;
    logic              tmo_q, tmo_nx;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            beat_cnt <= '0;
            hold_cnt <= '0;
            hold_f   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state    <= state_nx;
            beat_cnt <= beat_cnt_nx;
            hold_cnt <= hold_cnt_nx;
            hold_f   <= hold_f_nx;
            err_q    <= err_nx;
        end
    end

`ifdef BUS_REQ_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
            tmo_q    <= 1'b0;
        end else begin
            wait_cnt <= wait_cnt_nx;
            tmo_q    <= tmo_nx;
        end
    end
`endif

    always_comb begin
        state_nx      = state;
        beat_cnt_nx   = beat_cnt;
        hold_cnt_nx   = hold_cnt;
        hold_f_nx     = hold_f;
        err_nx        = err_q;
        bif.cmd_ready = 1'b0;
        bif.req       = 1'b0;
        bif.src_ready = 1'b0;
        bif.bus_valid = 1'b0;
        bif.bus_data  = '0;
        bif.done      = 1'b0;
        bif.dly       = 1'b0;
`ifdef BUS_REQ_TIMEOUT_EN
        wait_cnt_nx   = '0;
        tmo_nx        = tmo_q;
`endif
        unique case (state)
            IDLE: begin
                bif.cmd_ready = 1'b1;
                if (bif.cmd_valid) begin
                    beat_cnt_nx = bif.cmd_len;
                    hold_f_nx   = bif.cmd_hold;
                    state_nx    = REQ;
                end
            end
            REQ: begin
                bif.req = 1'b1;
                if (bif.gnt) begin
                    state_nx = XFER;
`ifdef BUS_REQ_TIMEOUT_EN
                end else if (wait_cnt == WC_W'(TIMEOUT - 1)) begin
                    state_nx = IDLE;
                    tmo_nx   = 1'b1;
                end else begin
                    wait_cnt_nx = wait_cnt + WC_W'(1);
`endif
                end
            end
            XFER: begin
                bif.req = 1'b1;
                // A dropped grant mid-transfer is flagged but the transfer just stalls.
                if (!bif.gnt) begin
                    err_nx = 1'b1;
                end else if (bif.src_valid) begin
                    bif.src_ready = 1'b1;
                    bif.bus_valid = 1'b1;
                    bif.bus_data  = bif.src_data;
                    if (beat_cnt == '0) begin
                        bif.done = 1'b1;
                        bif.dly  = hold_f;
                        if (hold_f) begin
                            state_nx    = HOLD;
                            hold_cnt_nx = HC_W'(HOLD_CYC - 1);
                        end else begin
                            state_nx = IDLE;
                        end
                    end else begin
                        beat_cnt_nx = beat_cnt - LEN_W'(1);
                    end
                end
            end
            HOLD: begin
                bif.dly = 1'b1;
                if (hold_cnt == '0) begin
                    state_nx = IDLE;
                end else begin
                    hold_cnt_nx = hold_cnt - HC_W'(1);
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign bif.busy = (state != IDLE);
    assign bif.err  = err_q;
`ifdef BUS_REQ_TIMEOUT_EN
    assign bif.timeout = tmo_q;
`else
    assign bif.timeout = 1'b0;
`endif
endmodule

// File: tb/tb_bus_requester.sv
// Directed bench for bus_requester with a beat scoreboard and a combinational arbiter.
// Arbiter grants whenever req is high unless gnt_block forces it low.
module tb_bus_requester;
    localparam int DATA_W   = 8;
    localparam int LEN_W    = 4;
    localparam int HOLD_CYC = 2;
    localparam int TIMEOUT  = 16;

    logic clk;
    logic rst_n;
    logic gnt_block;

    bus_requester_if #(.DATA_W(DATA_W), .LEN_W(LEN_W)) bif ();

    assign bif.gnt = bif.req & ~gnt_block;

    bus_requester #(
        .DATA_W  (DATA_W),
        .LEN_W   (LEN_W),
        .HOLD_CYC(HOLD_CYC),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bif  (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] d;
        logic       last;
        logic       hold;
    } beat_t;

    beat_t      exp_q[$];
    logic [7:0] src_q[$];
    int vectors, miscompares, cyc, beats, dones;
    int t0, b0, d0, n;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic monitor();
        beat_t e;
        if (bif.bus_valid === 1'b1) begin
            beats++;
            if (bif.done === 1'b1) dones++;
            chk("beat_src_ready", 32'(bif.src_ready), 1);
            chk("beat_src_valid", 32'(bif.src_valid), 1);
            if (exp_q.size() == 0) begin
                chk("unexpected_beat", 32'(exp_q.size()), 1);
            end else begin
                e = exp_q.pop_front();
                chk("bus_data", 32'(bif.bus_data), 32'(e.d));
                chk("done", 32'(bif.done), 32'(e.last));
                chk("dly_on_done", 32'(bif.dly), 32'(e.last & e.hold));
            end
            if (src_q.size() != 0) void'(src_q.pop_front());
            bif.src_data = (src_q.size() != 0) ? src_q[0] : 8'h00;
        end else begin
            chk("stall_done", 32'(bif.done), 0);
            chk("stall_src_ready", 32'(bif.src_ready), 0);
        end
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        monitor();
    endtask

    task automatic issue(input logic [3:0] len, input logic hold,
                         input logic [7:0] base, input logic expect_beats);
        chk("cmd_ready_idle", 32'(bif.cmd_ready), 1);
        bif.cmd_valid = 1'b1;
        bif.cmd_len   = len;
        bif.cmd_hold  = hold;
        if (expect_beats) begin
            for (int i = 0; i <= int'(len); i++) begin
                exp_q.push_back({base + 8'(i), (i == int'(len)), hold});
                src_q.push_back(base + 8'(i));
            end
            bif.src_data = src_q[0];
        end
        t0 = cyc;
        b0 = beats;
        d0 = dones;
        step();
        chk("req_after_accept", 32'(bif.req), 1);
        chk("cmd_ready_busy", 32'(bif.cmd_ready), 0);
        bif.cmd_valid = 1'b0;
    endtask

    task automatic drain(input string tag, input int budget);
        for (int k = 0; k < budget && exp_q.size() != 0; k++) step();
        chk(tag, 32'(exp_q.size()), 0);
    endtask

    initial begin
        vectors = 0; miscompares = 0; cyc = 0; beats = 0; dones = 0;
        rst_n = 1'b0;
        gnt_block = 1'b0;
        bif.cmd_valid = 1'b0;
        bif.cmd_len   = '0;
        bif.cmd_hold  = 1'b0;
        bif.src_valid = 1'b1;
        bif.src_data  = '0;

        step();
        chk("rst_cmd_ready", 32'(bif.cmd_ready), 1);
        chk("rst_req", 32'(bif.req), 0);
        chk("rst_busy", 32'(bif.busy), 0);
        chk("rst_dly", 32'(bif.dly), 0);
        chk("rst_bus_valid", 32'(bif.bus_valid), 0);
        chk("rst_bus_data", 32'(bif.bus_data), 0);
        chk("rst_err", 32'(bif.err), 0);
        chk("rst_timeout", 32'(bif.timeout), 0);
        rst_n = 1'b1;
        step();

        // 4 beats, no hold
        issue(4'd3, 1'b0, 8'h10, 1'b1);
        drain("t1_drain", 20);
        chk("t1_latency", 32'(cyc - t0), 5);
        chk("t1_beats", 32'(beats - b0), 4);
        chk("t1_dones", 32'(dones - d0), 1);
        step();
        chk("t1_idle_busy", 32'(bif.busy), 0);
        chk("t1_idle_req", 32'(bif.req), 0);

        // single beat with hold
        issue(4'd0, 1'b1, 8'h20, 1'b1);
        step();
        chk("t2_beats", 32'(beats - b0), 1);
        chk("t2_done_dly", 32'(bif.dly), 1);
        step();
        chk("t2_hold1_dly", 32'(bif.dly), 1);
        chk("t2_hold1_req", 32'(bif.req), 0);
        chk("t2_hold1_busy", 32'(bif.busy), 1);
        step();
        chk("t2_hold2_dly", 32'(bif.dly), 1);
        step();
        chk("t2_after_dly", 32'(bif.dly), 0);
        chk("t2_after_ready", 32'(bif.cmd_ready), 1);
        chk("t2_err", 32'(bif.err), 0);

        // source gaps
        issue(4'd2, 1'b0, 8'h30, 1'b1);
        for (int i = 0; i < 5; i++) begin
            bif.src_valid = (i % 2 == 0);
            step();
        end
        bif.src_valid = 1'b1;
        chk("t3_beats", 32'(beats - b0), 3);
        chk("t3_dones", 32'(dones - d0), 1);
        chk("t3_empty", 32'(exp_q.size()), 0);
        step();
        chk("t3_idle", 32'(bif.busy), 0);

        // grant dropped mid-transfer
        issue(4'd3, 1'b0, 8'h40, 1'b1);
        step();
        step();
        gnt_block = 1'b1;
        step();
        chk("t4_req_held", 32'(bif.req), 1);
        step();
        chk("t4_err_set", 32'(bif.err), 1);
        chk("t4_paused", 32'(beats - b0), 2);
        gnt_block = 1'b0;
        drain("t4_drain", 20);
        chk("t4_beats", 32'(beats - b0), 4);
        chk("t4_dones", 32'(dones - d0), 1);
        step();
        chk("t4_err_sticky", 32'(bif.err), 1);

        // reset mid-transfer
        issue(4'd3, 1'b0, 8'h50, 1'b1);
        step();
        step();
        rst_n = 1'b0;
        #1;
        chk("t5_busy", 32'(bif.busy), 0);
        chk("t5_req", 32'(bif.req), 0);
        chk("t5_bus_valid", 32'(bif.bus_valid), 0);
        chk("t5_done", 32'(bif.done), 0);
        chk("t5_cmd_ready", 32'(bif.cmd_ready), 1);
        chk("t5_err", 32'(bif.err), 0);
        chk("t5_dones", 32'(dones - d0), 0);
        exp_q.delete();
        src_q.delete();
        bif.src_data = '0;
        step();
        rst_n = 1'b1;
        step();
        issue(4'd1, 1'b0, 8'h60, 1'b1);
        drain("t5_drain", 20);
        chk("t5_new_beats", 32'(beats - b0), 2);
        chk("t5_new_dones", 32'(dones - d0), 1);
        step();

        // maximum length, no counter wrap
        issue(4'hF, 1'b0, 8'h80, 1'b1);
        drain("t6_drain", 40);
        chk("t6_beats", 32'(beats - b0), 16);
        chk("t6_dones", 32'(dones - d0), 1);
        step();
        chk("t6_idle", 32'(bif.busy), 0);

`ifdef BUS_REQ_TIMEOUT_EN
        gnt_block = 1'b1;
        issue(4'd2, 1'b0, 8'h90, 1'b0);
        n = 0;
        while (bif.req === 1'b1 && n < 40) begin
            n++;
            step();
        end
        chk("t7_req_cycles", 32'(n), 16);
        chk("t7_timeout", 32'(bif.timeout), 1);
        chk("t7_cmd_ready", 32'(bif.cmd_ready), 1);
        chk("t7_no_beats", 32'(beats - b0), 0);
        gnt_block = 1'b0;
`else
        chk("t7_timeout_tied", 32'(bif.timeout), 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule
